instr_encoder_loader: RTL and testbench

Other direction of the processor's control decoder. It accepts decoded instruction fields (opcode, func, registers, immediate, target) over a valid/ready stream and packs each into a 32-bit instruction word. Each word is written into instruction memory at an auto-incrementing address with a write/ack handshake. Used by the boot/program-load path and by the test harness to build programs without hand-assembled hex.

---
 rtl/instr_encoder_loader_pkg.sv | 37 +++
 rtl/instr_encoder_loader_packer.sv | 55 +++++
 rtl/instr_encoder_loader.sv | 161 ++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Processor ISA package: opcodes, R-type func range, field bit positions and
// instruction formats. Shared by the control decoder and the encoder/loader.
package instr_encoder_loader_pkg;

    // Opcodes live in bits [31:27]
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    // R-type ALU ops 00000..00111 are defined; anything above is reserved
    localparam logic [4:0] FUNC_LAST_LEGAL = 5'b00111;

    // Least-significant bit of each field in the 32-bit word
    localparam int OP_LSB    = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int FUNC_LSB  = 2;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_JI,
        FMT_JII,
        FMT_ILLEGAL
    } fmt_e;

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational field packer: decoded fields -> 32-bit instruction word.
// Also usable stand-alone as a golden encoder by assembler benches.
module instr_field_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [4:0]  func,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  shamt,
    input  logic [16:0] imm,
    input  logic [26:0] target,
    output logic [31:0] word,
    output fmt_e        fmt,
    output logic        illegal
);

    // Select the format from the opcode and place only the fields it uses
    always_comb begin
        word    = 32'd0;
        fmt     = FMT_ILLEGAL;
        illegal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                if (func <= FUNC_LAST_LEGAL) begin
                    fmt     = FMT_R;
                    illegal = 1'b0;
                    word    = (32'(opcode) << OP_LSB) | (32'(rd) << RD_LSB)
                            | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
                            | (32'(shamt) << SHAMT_LSB) | (32'(func) << FUNC_LSB);
                end
            end
            OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT: begin
                fmt     = FMT_I;
                illegal = 1'b0;
                word    = (32'(opcode) << OP_LSB) | (32'(rd) << RD_LSB)
                        | (32'(rs) << RS_LSB) | 32'(imm);
            end
            OP_J, OP_JAL, OP_SETX, OP_BEX: begin
                fmt     = FMT_JI;
                illegal = 1'b0;
                word    = (32'(opcode) << OP_LSB) | 32'(target);
            end
            OP_JR: begin
                fmt     = FMT_JII;
                illegal = 1'b0;
                word    = (32'(opcode) << OP_LSB) | (32'(rd) << RD_LSB);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts field bundles, packs them and writes the
// words to instruction memory at consecutive addresses with a we/ack handshake.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_func,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [16:0]       in_imm,
    input  logic [26:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    input  logic              imem_ack,
    output logic              done,
    output logic              err_illegal,
    output logic              err_full,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE, S_ERROR} state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              err_ill_q, err_ill_d;
    logic              err_full_q, err_full_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic [31:0] pk_word;
    fmt_e        pk_fmt;
    logic        pk_illegal;
    logic        bundle_bad;

    instr_field_packer u_packer (
        .opcode  (in_opcode),
        .func    (in_func),
        .rd      (in_rd),
        .rs      (in_rs),
        .rt      (in_rt),
        .shamt   (in_shamt),
        .imm     (in_imm),
        .target  (in_target),
        .word    (pk_word),
        .fmt     (pk_fmt),
        .illegal (pk_illegal)
    );

    // Either view of the packer result marks a bundle unusable; they agree by construction
    assign bundle_bad = pk_illegal | (pk_fmt == FMT_ILLEGAL);

    // Next-state and next-output logic for the load session
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        last_d     = last_q;
        done_d     = done_q;
        err_ill_d  = err_ill_q;
        err_full_d = err_full_q;
        count_d    = count_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_ACCEPT;
                    done_d     = 1'b0;
                    err_ill_d  = 1'b0;
                    err_full_d = 1'b0;
                    count_d    = '0;
                    addr_d     = BASE_C;
                end
            end
            S_ACCEPT: begin
                if (in_valid && in_ready_q) begin
                    if (bundle_bad) begin
                        err_ill_d = 1'b1;
                        state_d   = S_ERROR;
                    end else if (count_q == DEPTH_C) begin
                        err_full_d = 1'b1;
                        state_d    = S_ERROR;
                    end else begin
                        data_d  = pk_word;
                        last_d  = in_last;
                        we_d    = 1'b1;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // Address, data and request stay frozen until memory acknowledges
                if (imem_ack) begin
                    we_d    = 1'b0;
                    count_d = count_q + 1'b1;
                    addr_d  = addr_q + 1'b1;
                    done_d  = last_q;
                    state_d = last_q ? S_DONE : S_ACCEPT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_ACCEPT);
    end

    // State and registered outputs; reset wins over any in-flight write
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= BASE_C;
            data_q     <= 32'd0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            err_ill_q  <= 1'b0;
            err_full_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            last_q     <= last_d;
            done_q     <= done_d;
            err_ill_q  <= err_ill_d;
            err_full_q <= err_full_d;
            count_q    <= count_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_data   = data_q;
    assign done        = done_q;
    assign err_illegal = err_ill_q;
    assign err_full    = err_full_q;
    assign count       = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed sessions, a queue-based model of
// expected memory writes and sticky flags, and hand-computed word literals.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        in_opcode = '0, in_func = '0, in_rd = '0, in_rs = '0, in_rt = '0, in_shamt = '0;
    logic [16:0]       in_imm = '0;
    logic [26:0]       in_target = '0;
    logic              in_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              imem_ack = 1'b0;
    logic              done, err_illegal, err_full;
    logic [ADDR_W:0]   count;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_func(in_func), .in_rd(in_rd), .in_rs(in_rs),
        .in_rt(in_rt), .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
        .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data), .imem_ack(imem_ack),
        .done(done), .err_illegal(err_illegal), .err_full(err_full), .count(count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding straight from the ISA field table
    function automatic bit ref_encode(input logic [4:0] op, input logic [4:0] fn,
                                      input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] sh,
                                      input logic [16:0] imm, input logic [26:0] tgt,
                                      output logic [31:0] w);
        longint unsigned v;
        v = longint'(op) * (64'd1 << 27);
        w = 32'd0;
        if (op == 5'd0) begin
            if (fn > 5'd7) return 1'b0;
            v += longint'(rd) * (64'd1 << 22) + longint'(rs) * (64'd1 << 17)
               + longint'(rt) * (64'd1 << 12) + longint'(sh) * 128 + longint'(fn) * 4;
        end else if (op inside {5'd5, 5'd7, 5'd8, 5'd2, 5'd6}) begin
            v += longint'(rd) * (64'd1 << 22) + longint'(rs) * (64'd1 << 17) + longint'(imm);
        end else if (op inside {5'd1, 5'd3, 5'd21, 5'd22}) begin
            v += longint'(tgt);
        end else if (op == 5'd4) begin
            v += longint'(rd) * (64'd1 << 22);
        end else begin
            return 1'b0;
        end
        w = v[31:0];
        return 1'b1;
    endfunction

    typedef struct {
        int          addr;
        logic [31:0] data;
        bit          last;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] wl_data[$];
    int          wl_addr[$];

    int  m_count = 0, m_addr = 0;
    bit  m_done = 0, m_ill = 0, m_full = 0;
    bit  mon_en = 0;
    bit  prev_we = 0, prev_ack = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    int  we_run = 0, last_we_run = 0;
    int  ack_delay = 0, ack_wait = 0;

    // Memory responder: acknowledge after ack_delay cycles of request
    always @(posedge clock) begin
        #1;
        if (imem_we) begin
            imem_ack = (ack_wait >= ack_delay);
            ack_wait++;
        end else begin
            imem_ack = 1'b0;
            ack_wait = 0;
        end
    end

    // Compare process: check outputs against the model, then advance the model
    always @(negedge clock) begin
        if (mon_en) begin
            check("count", 64'(count), 64'(m_count));
            check("imem_addr", 64'(imem_addr), 64'(m_addr));
            check("done", 64'(done), 64'(m_done));
            check("err_illegal", 64'(err_illegal), 64'(m_ill));
            check("err_full", 64'(err_full), 64'(m_full));
            if (imem_we) check("ready_during_write", 64'(in_ready), 64'd0);
            if (prev_we && !prev_ack) begin
                check("we_hold", 64'(imem_we), 64'd1);
                check("addr_hold", 64'(imem_addr), 64'(prev_addr));
                check("data_hold", 64'(imem_data), 64'(prev_data));
            end
            if (reset) begin
                m_count = 0; m_addr = 0; m_done = 0; m_ill = 0; m_full = 0;
                exp_q.delete();
                prev_we = 0; prev_ack = 0; we_run = 0;
            end else begin
                if (start) begin
                    m_count = 0; m_addr = 0; m_done = 0; m_ill = 0; m_full = 0;
                end
                if (in_valid && in_ready) begin
                    logic [31:0] w;
                    if (!ref_encode(in_opcode, in_func, in_rd, in_rs, in_rt, in_shamt,
                                    in_imm, in_target, w))
                        m_ill = 1;
                    else if (m_count == DEPTH)
                        m_full = 1;
                    else
                        exp_q.push_back('{addr: m_addr, data: w, last: in_last});
                end
                if (imem_we) we_run++; else we_run = 0;
                if (imem_we && imem_ack) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 64'(imem_data), 64'hDEAD_0000_0000);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("write_addr", 64'(imem_addr), 64'(e.addr));
                        check("write_data", 64'(imem_data), 64'(e.data));
                        wl_data.push_back(imem_data);
                        wl_addr.push_back(int'(imem_addr));
                        last_we_run = we_run;
                        m_count++; m_addr++;
                        if (e.last) m_done = 1;
                    end
                end
                prev_we = imem_we; prev_ack = imem_ack;
                prev_addr = imem_addr; prev_data = imem_data;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] fn, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] sh,
                        input logic [16:0] imm, input logic [26:0] tgt, input logic last);
        bit ok;
        in_opcode = op; in_func = fn; in_rd = rd; in_rs = rs; in_rt = rt;
        in_shamt = sh; in_imm = imm; in_target = tgt; in_last = last;
        in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clock); #1 in_valid = 1'b0;
        $display("txn: op=%b func=%b rd=%0d rs=%0d rt=%0d imm=0x%0h tgt=0x%0h last=%0b accepted=%0b",
                 op, fn, rd, rs, rt, imm, tgt, last, ok);
    endtask

    task automatic wait_quiet();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (!imem_we && exp_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) check("write_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_imem_we", 64'(imem_we), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_imem_data", 64'(imem_data), 64'd0);
        check("rst_flags", 64'({done, err_illegal, err_full}), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        @(posedge clock); #1 reset = 1'b0; mon_en = 1;

        // Single R-type add, last
        wl_data.delete(); wl_addr.delete();
        pulse_start();
        check("start_ready", 64'(in_ready), 64'd1);
        send(5'd0, 5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 17'd0, 27'd0, 1'b1);
        wait_quiet();
        check("add_nwrites", 64'(wl_data.size()), 64'd1);
        if (wl_data.size() > 0) begin
            check("add_word", 64'(wl_data[0]), 64'h00C22000);
            check("add_addr", 64'(wl_addr[0]), 64'd0);
        end
        check("add_done", 64'(done), 64'd1);
        check("add_count", 64'(count), 64'd1);
        check("done_ready", 64'(in_ready), 64'd0);

        // addi then bne with negative immediate
        wl_data.delete(); wl_addr.delete();
        pulse_start();
        check("start_clears_done", 64'(done), 64'd0);
        send(5'd5, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 1'b0);
        send(5'd2, 5'd0, 5'd1, 5'd2, 5'd0, 5'd0, 17'h1FFFD, 27'd0, 1'b1);
        wait_quiet();
        check("ib_nwrites", 64'(wl_data.size()), 64'd2);
        if (wl_data.size() > 1) begin
            check("addi_word", 64'(wl_data[0]), 64'h28400005);
            check("addi_addr", 64'(wl_addr[0]), 64'd0);
            check("bne_word", 64'(wl_data[1]), 64'h1045FFFD);
            check("bne_addr", 64'(wl_addr[1]), 64'd1);
        end
        check("ib_count", 64'(count), 64'd2);

        // j with slow memory: request held four cycles
        wl_data.delete(); wl_addr.delete();
        ack_delay = 3;
        pulse_start();
        send(5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd100, 1'b1);
        wait_quiet();
        ack_delay = 0;
        check("j_nwrites", 64'(wl_data.size()), 64'd1);
        if (wl_data.size() > 0) check("j_word", 64'(wl_data[0]), 64'h08000064);
        check("j_we_cycles", 64'(last_we_run), 64'd4);

        // Illegal opcode, then recovery with jr
        wl_data.delete(); wl_addr.delete();
        pulse_start();
        send(5'b01111, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 17'd0, 27'd0, 1'b0);
        repeat (3) @(negedge clock);
        check("ill_flag", 64'(err_illegal), 64'd1);
        check("ill_we", 64'(imem_we), 64'd0);
        check("ill_ready", 64'(in_ready), 64'd0);
        check("ill_nwrites", 64'(wl_data.size()), 64'd0);
        pulse_start();
        check("ill_cleared", 64'(err_illegal), 64'd0);
        send(5'd4, 5'd0, 5'd31, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 1'b1);
        wait_quiet();
        check("jr_nwrites", 64'(wl_data.size()), 64'd1);
        if (wl_data.size() > 0) check("jr_word", 64'(wl_data[0]), 64'h27C00000);
        check("jr_done", 64'(done), 64'd1);

        // Capacity: DEPTH=2, third bundle overflows
        wl_data.delete(); wl_addr.delete();
        pulse_start();
        send(5'd5, 5'd0, 5'd1, 5'd1, 5'd0, 5'd0, 17'd1, 27'd0, 1'b0);
        send(5'd7, 5'd0, 5'd2, 5'd2, 5'd0, 5'd0, 17'd2, 27'd0, 1'b0);
        send(5'd8, 5'd0, 5'd3, 5'd3, 5'd0, 5'd0, 17'd3, 27'd0, 1'b0);
        wait_quiet();
        check("full_nwrites", 64'(wl_data.size()), 64'd2);
        check("full_flag", 64'(err_full), 64'd1);
        check("full_count", 64'(count), 64'd2);
        check("full_done", 64'(done), 64'd0);
        check("full_ready", 64'(in_ready), 64'd0);

        // Reset in the middle of a write
        ack_delay = 20;
        pulse_start();
        send(5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd7, 1'b1);
        @(negedge clock);
        check("pre_reset_we", 64'(imem_we), 64'd1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;
        check("mid_rst_we", 64'(imem_we), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        check("mid_rst_addr", 64'(imem_addr), 64'd0);
        check("mid_rst_data", 64'(imem_data), 64'd0);
        check("mid_rst_flags", 64'({done, err_illegal, err_full}), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        reset = 1'b0; ack_delay = 0;
        repeat (2) @(negedge clock);
        check("idle_no_ready", 64'(in_ready), 64'd0);
        pulse_start();
        check("restart_ready", 64'(in_ready), 64'd1);

        repeat (2) @(negedge clock);
        check("model_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
